if_fetch_unit: RTL and testbench

//   Instruction-fetch stage of the 5-stage MIPS core; directly upstream of the decode stage.
//   - Owns the PC and issues word fetches to instruction memory over a req/gnt request with an in-order rvalid response.
//   - Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
//   - Applies redirects from EX (branch/jump): flushes the FIFO and discards in-flight responses.

---
 rtl/if_fetch_unit_pkg.sv | 26 ++
 rtl/if_fetch_unit_if.sv | 38 +++
 rtl/if_fetch_unit_inst_fifo.sv | 57 +++++
 rtl/if_fetch_unit.sv | 100 ++++++++++
 tb/tb_if_fetch_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// Module   : if_fetch_unit_pkg
// Brief    : Shared constants, entry type and PC helper for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

  localparam int          c_inst_w   = 32;
  localparam int          c_pc_w     = 32;
  localparam logic [31:0] c_reset_pc = 32'hBFC0_0000;
  localparam logic [31:0] c_nop_inst = 32'h0000_0000;

  typedef struct packed {
    logic [c_pc_w-1:0]   pc;
    logic [c_inst_w-1:0] inst;
  } fetch_entry_t;

  function automatic logic [c_pc_w-1:0] align_pc(input logic [c_pc_w-1:0] pc);
    return {pc[c_pc_w-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module   : if_fetch_unit_if
// Brief    : Fetch-stage bus bundle: imem req/gnt/rvalid, EX redirect, decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_inst, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_inst, id_pc,
    output id_ready
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit_inst_fifo.sv
// ============================================================================
// Module   : if_inst_fifo
// Brief    : Synchronous {pc,inst} FIFO with push/pop/flush; flush beats push.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_inst_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               i_push,
  input  wire fetch_entry_t i_entry,
  input  wire               i_pop,
  input  wire               i_flush,
  output fetch_entry_t      o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic              o_empty,
  output logic              o_full
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH + 1);

  fetch_entry_t    r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + c_cw'(i_push) - c_cw'(i_pop);
    end
  end

  // Storage needs no reset: the head is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_cw'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Brief    : MIPS IF stage: PC owner, credit-limited imem fetch, redirect/flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = c_reset_pc,
  parameter int          FIFO_DEPTH = 2
) (
  input  wire             clk,
  input  wire             rst,
  if_fetch_unit_if.master bus
);

  localparam int c_cw = $clog2(FIFO_DEPTH + 1);
  localparam int c_sw = c_cw + 1;

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [c_cw-1:0] r_outstanding;
  logic [c_cw-1:0] r_drop_cnt;

  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic [c_cw-1:0] w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic [c_sw-1:0] w_credit_used;
  logic            w_req;
  logic            w_xfer;
  logic            w_push;
  logic            w_pop;
  logic            w_dropping;
  logic            w_id_valid;
  logic [c_cw-1:0] w_out_after_rv;
  logic [31:0]     w_redirect_pc;

  // Every request in flight has a reserved FIFO slot, so a response never meets a full FIFO.
  assign w_credit_used  = c_sw'(r_outstanding) + c_sw'(w_fifo_count);
  assign w_req          = !rst && !bus.redirect_valid && (w_credit_used < c_sw'(FIFO_DEPTH));
  assign w_xfer         = w_req && bus.imem_gnt;
  assign w_dropping     = bus.imem_rvalid && (r_drop_cnt != '0);
  assign w_push         = bus.imem_rvalid && (r_drop_cnt == '0) && !bus.redirect_valid;
  assign w_id_valid     = !w_fifo_empty;
  assign w_pop          = w_id_valid && bus.id_ready;
  assign w_out_after_rv = r_outstanding - c_cw'(bus.imem_rvalid);
  assign w_redirect_pc  = align_pc(bus.redirect_pc);
  assign w_push_entry   = '{pc: r_resp_pc, inst: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (bus.redirect_valid) begin
      // No request issues in a redirect cycle, so only the response side moves.
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= w_out_after_rv;
      r_drop_cnt    <= w_out_after_rv;
    end else begin
      if (w_xfer)     r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push)     r_resp_pc  <= r_resp_pc + 32'd4;
      if (w_dropping) r_drop_cnt <= r_drop_cnt - 1'b1;
      r_outstanding <= r_outstanding + c_cw'(w_xfer) - c_cw'(bus.imem_rvalid);
    end
  end

  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.id_valid  = w_id_valid;
  assign bus.id_inst   = w_id_valid ? w_head.inst : c_nop_inst;
  assign bus.id_pc     = w_id_valid ? w_head.pc   : 32'h0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_fifo_full && !w_pop));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Randomized scoreboard bench for if_fetch_unit with an in-order imem model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int          c_depth = 2;
  localparam logic [31:0] c_rpc   = 32'hBFC0_0000;
  localparam int          c_cycles = 3000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_unit_if bus();

  if_fetch_unit #(
    .RESET_PC   (c_rpc),
    .FIFO_DEPTH (c_depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  exp_q  [$];
  pend_t pend_q [$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    n_pops = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_1E0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every decode pop must match the oldest expected fetch.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #1;
      if (rst === 1'b0 && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale_pop: got pc %08h expected no valid entry", bus.id_pc);
        end else begin
          e = exp_q.pop_front();
          check32("id_pc", bus.id_pc, e.pc);
          check32("id_inst", bus.id_inst, e.inst);
          n_pops++;
        end
      end
    end
  end

  // Stimulus, imem model and program-order reference.
  initial begin
    logic [31:0] model_pc;
    int          live;
    int          nonstale;
    int          used;
    int          dly;
    bit          exp_req;

    rst                = 1'b1;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    model_pc           = c_rpc;
    live               = 0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check1("rst_imem_req", bus.imem_req, 1'b0);
      check1("rst_id_valid", bus.id_valid, 1'b0);
    end

    for (int cyc = 0; cyc < c_cycles; cyc++) begin
      @(negedge clk);
      rst = 1'b0;

      if (cyc < 20 || (cyc >= 45 && cyc < 51) || cyc == 65)
        bus.imem_gnt = 1'b1;
      else if (cyc >= 60 && cyc < 65)
        bus.imem_gnt = 1'b0;
      else
        bus.imem_gnt = ($urandom_range(0, 9) < 7);

      bus.id_ready = (cyc < 20) ? 1'b1 : ($urandom_range(0, 9) < 7);

      if (cyc == 25) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
      end else if (cyc == 45) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
      end else if (cyc >= 70 && $urandom_range(0, 99) < 5) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      end else begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = $urandom;
      end

      if (pend_q.size() > 0 && pend_q[0].due <= cyc && (cyc < 20 || $urandom_range(0, 3) != 0)) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_q[0].addr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end

      #2;
      nonstale = 0;
      foreach (pend_q[i]) if (!pend_q[i].stale) nonstale++;
      used    = pend_q.size() + (live - nonstale);
      exp_req = !bus.redirect_valid && (used < c_depth);

      check1("imem_req", bus.imem_req, exp_req);
      if (exp_req) check32("imem_addr", bus.imem_addr, model_pc);
      if (bus.id_valid !== 1'b1) begin
        check32("nop_inst", bus.id_inst, 32'h0);
        check32("nop_pc", bus.id_pc, 32'h0);
      end
      if (cyc == 0) check32("first_addr", bus.imem_addr, 32'hBFC0_0000);
      if (cyc == 1) check1("latency_early", bus.id_valid, 1'b0);
      if (cyc == 2) check1("latency_first", bus.id_valid, 1'b1);

      if (bus.imem_rvalid) void'(pend_q.pop_front());
      if (bus.id_valid && bus.id_ready) live--;
      if (bus.imem_req && bus.imem_gnt) begin
        dly = (cyc < 20) ? 0 : $urandom_range(0, 2);
        pend_q.push_back('{model_pc, 1'b0, cyc + 1 + dly});
        exp_q.push_back('{model_pc, mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
        live++;
      end
      if (bus.redirect_valid) begin
        model_pc = {bus.redirect_pc[31:2], 2'b00};
        exp_q.delete();
        live = 0;
        foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      end
      check1("credit_bound", pend_q.size() <= c_depth, 1'b1);
    end

    check1("progress", n_pops > 100, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
